// File: rtl/countdown_timer_bcd_pkg.sv
// Shared definitions for the BCD countdown timer: state encodings,
// digit width, default digit limits and the load clamp helper.
package countdown_timer_bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DEFAULT_MAX_MIN     = 4'd9;
    localparam logic [DIGIT_W-1:0] DEFAULT_MAX_TEN_SEC = 4'd5;
    localparam logic [DIGIT_W-1:0] DEFAULT_MAX_SEC     = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Saturate an entered digit to the largest value that digit may hold.
    function automatic logic [DIGIT_W-1:0] bcd_clamp(
        input logic [DIGIT_W-1:0] value,
        input logic [DIGIT_W-1:0] max_value
    );
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit.sv
// One BCD down-counting digit: clear, clamped load, decrement with reload
// to MAX_VALUE on underflow, and a borrow flag while the digit sits at 0.
module bcd_digit_down
    import countdown_timer_bcd_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX_VALUE = 4'd9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_value,
    input  logic               dec,
    output logic [DIGIT_W-1:0] value,
    output logic               borrow
);

    logic [DIGIT_W-1:0] value_reg;

    // Digit register: reset/clear beat load, load beats decrement.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value_reg <= '0;
        end else if (load) begin
            value_reg <= bcd_clamp(load_value, MAX_VALUE);
        end else if (dec) begin
            value_reg <= (value_reg == '0) ? MAX_VALUE : value_reg - 4'd1;
        end
    end

    assign value  = value_reg;
    assign borrow = (value_reg == '0);

endmodule

// File: rtl/countdown_timer_bcd.sv
// M:SS BCD countdown timer: loads entered digits, counts down once per
// rising edge of the 1 Hz tick while started, and flags zero/done.
module countdown_timer_bcd
    import countdown_timer_bcd_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX_MIN     = DEFAULT_MAX_MIN,
    parameter logic [DIGIT_W-1:0] MAX_TEN_SEC = DEFAULT_MAX_TEN_SEC,
    parameter logic [DIGIT_W-1:0] MAX_SEC     = DEFAULT_MAX_SEC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               loadn,
    input  logic               start,
    input  logic               clearn,
    input  logic               tick,
    input  logic [DIGIT_W-1:0] data_sec,
    input  logic [DIGIT_W-1:0] data_ten_sec,
    input  logic [DIGIT_W-1:0] data_min,
    output logic [DIGIT_W-1:0] sec,
    output logic [DIGIT_W-1:0] ten_sec,
    output logic [DIGIT_W-1:0] min,
    output logic               zero,
    output logic               running,
    output logic               done
);

    localparam int NUM_DIGITS = 3;

    // Digit 0 = seconds, 1 = tens of seconds, 2 = minutes.
    localparam logic [NUM_DIGITS*DIGIT_W-1:0] MAX_VEC = {MAX_MIN, MAX_TEN_SEC, MAX_SEC};

    state_t state_reg, state_next;
    logic   tick_d_reg;
    logic   done_reg, done_next;
    logic   dec_en;
    logic   tick_rise;
    logic   load_nonzero;
    logic   count_is_one;

    logic [NUM_DIGITS*DIGIT_W-1:0] load_vec;
    logic [DIGIT_W-1:0]            digit_value [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]         digit_borrow;
    logic [NUM_DIGITS-1:0]         dec_chain;

    assign load_vec  = {data_min, data_ten_sec, data_sec};
    assign tick_rise = tick & ~tick_d_reg;

    // A load counts as non-zero only after clamping.
    assign load_nonzero = |{bcd_clamp(data_min, MAX_MIN),
                            bcd_clamp(data_ten_sec, MAX_TEN_SEC),
                            bcd_clamp(data_sec, MAX_SEC)};

    assign count_is_one = (digit_value[2] == '0) && (digit_value[1] == '0)
                       && (digit_value[0] == 4'd1);

    // Borrow ripples upward: a digit decrements only when every digit
    // below it is at zero in the same cycle.
    assign dec_chain[0] = dec_en;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi > 0) begin : g_chain
                assign dec_chain[gi] = dec_chain[gi-1] & digit_borrow[gi-1];
            end
            bcd_digit_down #(
                .MAX_VALUE(MAX_VEC[gi*DIGIT_W +: DIGIT_W])
            ) u_digit (
                .clk        (clk),
                .rst        (rst),
                .clr        (~clearn),
                .load       (~loadn),
                .load_value (load_vec[gi*DIGIT_W +: DIGIT_W]),
                .dec        (dec_chain[gi]),
                .value      (digit_value[gi]),
                .borrow     (digit_borrow[gi])
            );
        end
    endgenerate

    // Tick history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_d_reg <= 1'b0;
        end else begin
            tick_d_reg <= tick;
        end
    end

    // State and done-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    // Next-state, decrement enable and done detection; clear beats load,
    // load beats counting.
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        dec_en     = 1'b0;
        if (!clearn) begin
            state_next = IDLE;
        end else if (!loadn) begin
            state_next = load_nonzero ? LOADED : IDLE;
        end else begin
            case (state_reg)
                IDLE: state_next = IDLE;
                LOADED: begin
                    if (start) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!start) begin
                        state_next = LOADED;
                    end else if (tick_rise && !zero) begin
                        dec_en = 1'b1;
                        if (count_is_one) begin
                            done_next  = 1'b1;
                            state_next = DONE;
                        end
                    end
                end
                DONE: state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign sec     = digit_value[0];
    assign ten_sec = digit_value[1];
    assign min     = digit_value[2];
    assign zero    = &digit_borrow;
    assign running = (state_reg == RUN);
    assign done    = done_reg;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Scoreboard bench for countdown_timer_bcd: a seconds-based reference model
// predicts each cycle's outputs, queued at drive time, popped after the edge.
module tb_countdown_timer_bcd;

    logic       clk;
    logic       rst;
    logic       loadn;
    logic       start;
    logic       clearn;
    logic       tick;
    logic [3:0] data_sec;
    logic [3:0] data_ten_sec;
    logic [3:0] data_min;
    logic [3:0] sec;
    logic [3:0] ten_sec;
    logic [3:0] min;
    logic       zero;
    logic       running;
    logic       done;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] ten;
        logic [3:0] sec;
        logic       zero;
        logic       running;
        logic       done;
    } exp_t;

    exp_t exp_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: count held as total seconds.
    int m_total = 0;
    int m_state = 0;   // 0 idle, 1 loaded, 2 run, 3 done
    bit m_tick_d = 0;

    countdown_timer_bcd dut (
        .clk          (clk),
        .rst          (rst),
        .loadn        (loadn),
        .start        (start),
        .clearn       (clearn),
        .tick         (tick),
        .data_sec     (data_sec),
        .data_ten_sec (data_ten_sec),
        .data_min     (data_min),
        .sec          (sec),
        .ten_sec      (ten_sec),
        .min          (min),
        .zero         (zero),
        .running      (running),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Advance the model with the inputs currently driven, queue the
    // prediction, clock the DUT, then compare against the popped entry.
    task automatic cycle(input string tag);
        exp_t e;
        exp_t got;
        bit   rise;
        bit   done_n;
        rise   = tick && !m_tick_d;
        done_n = 0;
        if (rst) begin
            m_total  = 0;
            m_state  = 0;
            m_tick_d = 0;
        end else begin
            m_tick_d = tick;
            if (!clearn) begin
                m_total = 0;
                m_state = 0;
            end else if (!loadn) begin
                m_total = clamp(data_min, 9) * 60 + clamp(data_ten_sec, 5) * 10
                        + clamp(data_sec, 9);
                m_state = (m_total != 0) ? 1 : 0;
            end else if (m_state == 1) begin
                if (start) m_state = 2;
            end else if (m_state == 2) begin
                if (!start) begin
                    m_state = 1;
                end else if (rise && m_total > 0) begin
                    if (m_total == 1) begin
                        done_n  = 1;
                        m_state = 3;
                    end
                    m_total = m_total - 1;
                end
            end
        end
        e.min     = 4'(m_total / 60);
        e.ten     = 4'((m_total % 60) / 10);
        e.sec     = 4'(m_total % 10);
        e.zero    = (m_total == 0);
        e.running = (m_state == 2);
        e.done    = done_n;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        got = {min, ten_sec, sec, zero, running, done};
        $display("[TB] %-14s count=%0d:%0d%0d zero=%0d running=%0d done=%0d", tag,
                 min, ten_sec, sec, zero, running, done);
        check_value({tag, " count"}, {20'd0, got.min, got.ten, got.sec},
                    {20'd0, e.min, e.ten, e.sec});
        check_value({tag, " zero"}, {31'd0, got.zero}, {31'd0, e.zero});
        check_value({tag, " running"}, {31'd0, got.running}, {31'd0, e.running});
        check_value({tag, " done"}, {31'd0, got.done}, {31'd0, e.done});
    endtask

    task automatic do_load(input string tag, input int m, input int t, input int s);
        data_min     = 4'(m);
        data_ten_sec = 4'(t);
        data_sec     = 4'(s);
        loadn        = 1'b0;
        cycle(tag);
        loadn        = 1'b1;
    endtask

    task automatic do_tick(input string tag);
        tick = 1'b1;
        cycle(tag);
        tick = 1'b0;
        cycle({tag, "_low"});
    endtask

    initial begin
        rst = 1'b1; loadn = 1'b1; start = 1'b0; clearn = 1'b1; tick = 1'b0;
        data_sec = '0; data_ten_sec = '0; data_min = '0;
        cycle("reset0");
        cycle("reset1");
        rst = 1'b0;
        cycle("idle");

        // 1:30 counting down three seconds
        do_load("load_1_30", 1, 3, 0);
        start = 1'b1;
        cycle("to_run");
        for (int i = 0; i < 3; i++) do_tick("tick_1_30");

        // 0:02 to done, then an extra tick at 0:00
        do_load("load_0_02", 0, 0, 2);
        cycle("to_run");
        for (int i = 0; i < 3; i++) do_tick("tick_0_02");
        cycle("done_hold");

        // Both borrows, then single borrow
        do_load("load_1_00", 1, 0, 0);
        cycle("to_run");
        do_tick("tick_1_00");
        do_load("load_0_10", 0, 1, 0);
        cycle("to_run");
        do_tick("tick_0_10");

        // Clamped load with start low
        start = 1'b0;
        do_load("load_clamp", 9, 8, 11);
        cycle("clamp_hold");
        do_load("load_zero", 0, 0, 0);

        // Pause and resume; tick during LOADED->RUN is ignored
        do_load("load_0_05", 0, 0, 5);
        start = 1'b1;
        tick  = 1'b1;
        cycle("run_tick_ign");
        tick  = 1'b0;
        cycle("run_tick_low");
        for (int i = 0; i < 2; i++) do_tick("tick_0_05");
        start = 1'b0;
        tick  = 1'b1;
        cycle("pause_vs_tick");
        tick  = 1'b0;
        cycle("paused");
        for (int i = 0; i < 3; i++) do_tick("paused_tick");
        start = 1'b1;
        cycle("resume");
        do_tick("resume_tick");

        // Clear while running
        do_load("load_0_40a", 0, 4, 0);
        cycle("to_run");
        do_tick("tick_0_40a");
        clearn = 1'b0;
        cycle("clear");
        clearn = 1'b1;
        cycle("after_clear");

        // Reset while running
        do_load("load_0_40b", 0, 4, 0);
        cycle("to_run");
        rst = 1'b1;
        cycle("mid_reset");
        rst = 1'b0;
        cycle("after_reset");

        // Reload while running; ticks under loadn must not count
        do_load("load_0_40c", 0, 4, 0);
        cycle("to_run");
        data_min = 4'd0; data_ten_sec = 4'd1; data_sec = 4'd5;
        loadn = 1'b0;
        tick  = 1'b1;
        cycle("reload_tick");
        tick  = 1'b0;
        cycle("reload_low");
        tick  = 1'b1;
        cycle("reload_tick2");
        tick  = 1'b0;
        loadn = 1'b1;
        cycle("reload_done");
        cycle("to_run");
        do_tick("tick_0_15");

        if (exp_q.size() != 0) check_value("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- Downstream consumer of the keypad timer-entry stage: takes the entered M:SS BCD digits on an active-low load and counts them down once per rising edge of the 1 Hz tick.
- Produces the live BCD digits for the seven-segment decoders and a zero/done indication to the microwave control logic (magnetron enable, buzzer).

Parameters:
- MAX_MIN, 9, upper clamp for the minutes digit on load.
- MAX_TEN_SEC, 5, upper clamp for the tens-of-seconds digit on load; also the reload value on borrow.
- MAX_SEC, 9, upper clamp for the units-of-seconds digit on load; also the reload value on borrow.

Ports:
- clk  in  1  system clock (the same 100 Hz clock that feeds the entry stage and divider).
- rst  in  1  synchronous, active-high reset.
- loadn  in  1  active-low load; while 0, the data_* inputs are copied into the count every cycle.
- start  in  1  level; 1 = counting permitted (door closed and start pressed).
- clearn  in  1  active-low clear; zeroes the count and returns to IDLE.
- tick  in  1  1 Hz square wave (pgt_1Hz); only its rising edge is used.
- data_sec  in  4  BCD units of seconds to load.
- data_ten_sec  in  4  BCD tens of seconds to load.
- data_min  in  4  BCD units of minutes to load.
- sec  out  4  current BCD units of seconds.
- ten_sec  out  4  current BCD tens of seconds.
- min  out  4  current BCD minutes.
- zero  out  1  1 when the count is 0:00.
- running  out  1  1 in RUN state (drives the magnetron enable).
- done  out  1  single-cycle pulse on the 0:01 -> 0:00 transition in RUN.

Behaviour:
- All state updates on posedge clk. rst is synchronous and active-high.
- Reset values: sec=0, ten_sec=0, min=0, zero=1, running=0, done=0, state=IDLE, tick_d=0.
- Tick edge detect: tick_d registered each cycle; tick_rise = tick & ~tick_d. tick is treated as synchronous to clk.
- Priority, highest first: rst, clearn=0, loadn=0, tick_rise decrement.
- clearn=0: count := 0:00; state := IDLE.
- loadn=0:
  - Each digit clamps to its MAX_* value if above it; e.g. data_ten_sec=7 loads 5, data_sec=12 loads 9.
  - state := LOADED if the clamped value is non-zero, else IDLE.
  - Counting is suppressed while loadn=0, even if start=1.
- State machine:
  - IDLE: count=0:00. Remain until loadn=0 loads a non-zero value -> LOADED.
  - LOADED (paused): if start=1 -> RUN on the next cycle. No decrement occurs in the transition cycle.
  - RUN:
    - running=1.
    - start=0 -> LOADED; the count is held (pause for door opening).
    - tick_rise with start=1 -> decrement by one second.
    - If the pre-decrement count is 0:01 -> count becomes 0:00, done=1 for one cycle, state -> DONE.
  - DONE: count=0:00, running=0. Any load -> LOADED/IDLE per the load rule. clearn -> IDLE.
- Decrement arithmetic (BCD, borrow chain):
  - sec>0: sec-1.
  - Else sec := MAX_SEC. Then ten_sec>0: ten_sec-1.
  - Else ten_sec := MAX_TEN_SEC, min-1.
  - The count never wraps below 0:00. A tick_rise at 0:00 is ignored.
- tick_rise in the same cycle as the LOADED->RUN transition: ignored. The first decrement is on the next rising edge.
- start dropping in the same cycle as tick_rise: the pause wins; no decrement occurs.
- zero is combinational from the count registers (min==0 && ten_sec==0 && sec==0).
- Latency: outputs reflect a load or decrement one clk after the triggering edge.
- Reset mid-RUN: the next cycle matches the reset values exactly; done is not pulsed.

Decomposition:
- Shared package/header:
  - State encodings: IDLE=2'd0, LOADED=2'd1, RUN=2'd2, DONE=2'd3.
  - BCD digit width (4).
  - MAX_* defaults.
- One natural sub-module: bcd_digit_down, a single BCD digit with load, decrement-enable, programmable max, and a borrow-out when the digit is 0. The block instantiates three of these, chained via borrow.
- Edge detect and FSM stay in the top level.

Test Plan:
- Load 1:30 (loadn=0 for one cycle), start=1, 3 tick rises -> 1:29, 1:28, 1:27; running=1; zero=0.
- Load 0:02, start=1, 2 tick rises -> 0:01 then 0:00; done pulses for exactly one cycle; state DONE; running=0; a third tick leaves 0:00.
- Load 1:00, run one tick -> 0:59 (both borrows). Load 0:10, one tick -> 0:09.
- Load with data_min=9, data_ten_sec=8, data_sec=11 -> count 9:59 (clamped).
- Load 0:05, run 2 ticks (0:03), start=0, 3 tick rises -> the count holds at 0:03; start=1, one tick -> 0:02.
- Mid-RUN at 0:40: assert clearn=0 -> 0:00, IDLE. Separately, assert rst at 0:40 -> all reset values next cycle, no done pulse. Separately, assert loadn=0 with 0:15 while running -> 0:15, LOADED, no decrement while loadn is low.
